fx2_fifo_arbiter: RTL
=====================

Name: fx2_fifo_arbiter

Overview:
- Shares the single FX2 slave-FIFO bus between three requesters:
  - host command reads from FIFO2 (EP2);
  - logic-analyzer capture writes to FIFO4 (EP6);
  - command response writes to FIFO5 (EP8).
- Sequences FIFOADR settling, bus direction, RD/WR strobes and PKTEND, so that the capture stream and the control path coexist on one USB link.
- Sits between the board-level active-high FIFO signals and the probe/capture and command-processor blocks.

Parameters:
- BURST, 64: maximum transfers per grant before re-arbitration.
- PKT_TIMEOUT, 4095: idle cycles on the capture channel, after at least one capture byte, before a FIFO4 PKTEND is forced.
- TO_W, 12: width of the timeout counter; must satisfy PKT_TIMEOUT < 2^TO_W.

Ports:
- FIFO_clk  in  1  clock
- reset  in  1  asynchronous, active-high
- FIFO2_data_available  in  1  FX2 EP2 not empty
- FIFO4_ready_to_accept_data  in  1  EP6 not full
- FIFO5_ready_to_accept_data  in  1  EP8 not full
- FIFO_DATAIN  in  8  FX2 FD read data
- FIFO_RD, FIFO_WR, FIFO_PKTEND  out  1 each  active-high strobes
- FIFO_DATAIN_OE, FIFO_DATAOUT_OE  out  1 each  bus direction
- FIFO_FIFOADR  out  2  00=FIFO2, 10=FIFO4, 11=FIFO5 (01 never driven)
- cap_valid  in  1; cap_data  in  8; cap_ready  out  1  capture source
- rsp_valid  in  1; rsp_data  in  8; rsp_last  in  1; rsp_ready  out  1  response source
- cmd_valid  out  1; cmd_data  out  8; cmd_ready  in  1  command sink

Behaviour:
- Reset (async, active-high) drives all of the following to their reset values: RD/WR/PKTEND=0, DATAIN_OE=0, DATAOUT_OE=0, FIFOADR=00, cmd_valid=0, cmd_data=0, cap_ready=0, rsp_ready=0. The FSM returns to IDLE and the round-robin pointer resets to CMD.
- Requests:
  - CMD requests when FIFO2_data_available & cmd_ready & ~cmd_valid.
  - RSP requests when rsp_valid & FIFO5 ready.
  - CAP requests when cap_valid & FIFO4 ready.
  - TOUT (pending FIFO4 PKTEND) is serviced as a CAP-channel grant.
- Arbitration: round-robin in the order CMD→RSP→CAP, starting after the last granted channel. RSP is never pre-empted mid-packet: it holds the grant until rsp_last, ignoring BURST.
- FSM states: IDLE, SETTLE, XFER, PKTEND.
  - IDLE: if any request, latch grant and register FIFOADR → SETTLE.
  - SETTLE: exactly 1 cycle; no strobes; DATAOUT_OE=1 for write grants, DATAIN_OE=1 for CMD → XFER.
  - XFER, CMD: FIFO_RD = request term. At that edge FIFO_DATAIN is captured into cmd_data and cmd_valid rises next cycle. cmd_valid is held until cmd_valid&cmd_ready, so there is at most one byte in flight. Leave XFER after 1 byte.
  - XFER, CAP/RSP: ready = state XFER & FIFO ready; FIFO_WR = valid & ready. FIFO_DATAOUT = selected data (combinational mux).
  - CAP exit: leave XFER when the burst count reaches BURST, when valid drops, or when the FIFO fills.
  - RSP exit: a write with rsp_last → PKTEND.
  - PKTEND: 1 cycle, FIFO_PKTEND=1, WR=0, FIFOADR unchanged → IDLE.
- Burst counter: 7 bits, counting transfers within a grant; cleared on each grant.
- Timeout:
  - Counter increments while the CAP dirty flag is set and no CAP write occurs; it clears on every CAP write.
  - On reaching PKT_TIMEOUT, TOUT is set. When granted, the FSM goes SETTLE(FIFO4)→PKTEND, clearing the dirty flag and TOUT.
- Boundaries:
  - FIFO goes full mid-burst: WR drops the same cycle; no byte is lost (cap_ready low).
  - Simultaneous requests: the round-robin pointer decides.
  - Reset mid-transfer: strobes drop immediately; any partial RSP packet is abandoned and the source must restart it.
- The direction enables are never both 1. DATAOUT_OE=0 whenever FIFOADR=00.

Decomposition:
- Shared package fx2_pkg:
  - FIFOADR encodings FX2_ADR_EP2=2'b00, FX2_ADR_EP6=2'b10, FX2_ADR_EP8=2'b11;
  - FSM state encodings;
  - channel IDs CH_CMD/CH_RSP/CH_CAP.
- One sub-module: rr_arbiter3 (3-way round-robin, request/grant, pointer update on grant).

Test Plan:
- Reset assert mid-XFER → all strobes and OEs go to 0 within the same cycle; FIFOADR=00; cmd_valid=0.
- Only cap_valid=1 continuously, FIFO4 ready → FIFOADR=10. Expect 64 WR cycles, then IDLE and SETTLE gaps (2 cycles), then a new burst, with bytes 0x00..0xFF in order.
- FIFO2 holds 0xA5, cmd_ready=1 → single RD pulse, then cmd_valid=1 with cmd_data=0xA5, held until cmd_ready.
- 3-byte response 0x01,0x02,0x03 with rsp_last on 0x03, while cap_valid=1 → RSP completes uninterrupted, PKTEND pulses once at FIFOADR=11, then CAP is granted.
- 5 capture bytes, then cap_valid=0 → exactly PKT_TIMEOUT cycles later a PKTEND sequence at FIFOADR=10; no second PKTEND without new data.
- FIFO4 full during a burst → WR and cap_ready low the same cycle, no data skipped; CMD/RSP requests are still served.

Source files
------------

// File: rtl/fx2_pkg.sv
// Shared encodings for the FX2 slave-FIFO arbiter: FIFOADR values, FSM states
// and requester channel IDs.
package fx2_pkg;

  localparam logic [1:0] FX2_ADR_EP2 = 2'b00;
  localparam logic [1:0] FX2_ADR_EP6 = 2'b10;
  localparam logic [1:0] FX2_ADR_EP8 = 2'b11;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_XFER   = 2'd2;
  localparam logic [1:0] ST_PKTEND = 2'd3;

  localparam logic [1:0] CH_CMD = 2'd0;
  localparam logic [1:0] CH_RSP = 2'd1;
  localparam logic [1:0] CH_CAP = 2'd2;

  function automatic logic [1:0] ch_to_adr(input logic [1:0] ch);
    case (ch)
      CH_RSP:  return FX2_ADR_EP8;
      CH_CAP:  return FX2_ADR_EP6;
      default: return FX2_ADR_EP2;
    endcase
  endfunction

endpackage

// File: rtl/fx2_fifo_arbiter_rr.sv
// Three-way round-robin arbiter; the pointer names the channel with highest
// priority and moves just past the winner whenever a grant is taken.
module rr_arbiter3
  import fx2_pkg::*;
(
  input  logic       FIFO_clk,
  input  logic       reset,
  input  logic [2:0] req,
  input  logic       take,
  output logic       gnt_valid,
  output logic [1:0] gnt_ch
);

  logic [1:0] ptr;
  logic [1:0] alt1;
  logic [1:0] alt2;

  function automatic logic [1:0] next_ch(input logic [1:0] ch);
    return (ch == CH_CAP) ? CH_CMD : ch + 2'd1;
  endfunction

  always_comb begin
    alt1      = next_ch(ptr);
    alt2      = next_ch(alt1);
    gnt_valid = 1'b1;
    gnt_ch    = ptr;
    if (req[ptr])       gnt_ch = ptr;
    else if (req[alt1]) gnt_ch = alt1;
    else if (req[alt2]) gnt_ch = alt2;
    else                gnt_valid = 1'b0;
  end

  always_ff @(posedge FIFO_clk or posedge reset) begin
    if (reset)                  ptr <= CH_CMD;
    else if (take && gnt_valid) ptr <= next_ch(gnt_ch);
  end

endmodule

// File: rtl/fx2_fifo_arbiter.sv
// FX2 slave-FIFO bus arbiter: shares FD/FIFOADR between host commands (EP2),
// the capture stream (EP6) and command responses (EP8).
// state  | meaning
// IDLE   | choose next channel, register FIFOADR
// SETTLE | FIFOADR settles, bus direction enabled, no strobes
// XFER   | RD/WR strobes for the granted channel
// PKTEND | one-cycle PKTEND on the granted FIFO
module fx2_fifo_arbiter
  import fx2_pkg::*;
#(
  parameter int BURST       = 64,
  parameter int PKT_TIMEOUT = 4095,
  parameter int TO_W        = 12
) (
  input  logic       FIFO_clk,
  input  logic       reset,
  input  logic       FIFO2_data_available,
  input  logic       FIFO4_ready_to_accept_data,
  input  logic       FIFO5_ready_to_accept_data,
  input  logic [7:0] FIFO_DATAIN,
  output logic       FIFO_RD,
  output logic       FIFO_WR,
  output logic       FIFO_PKTEND,
  output logic       FIFO_DATAIN_OE,
  output logic       FIFO_DATAOUT_OE,
  output logic [1:0] FIFO_FIFOADR,
  output logic [7:0] FIFO_DATAOUT,
  input  logic       cap_valid,
  input  logic [7:0] cap_data,
  output logic       cap_ready,
  input  logic       rsp_valid,
  input  logic [7:0] rsp_data,
  input  logic       rsp_last,
  output logic       rsp_ready,
  output logic       cmd_valid,
  output logic [7:0] cmd_data,
  input  logic       cmd_ready
);

  localparam logic [6:0]      BURST_LAST = 7'(BURST - 1);
  localparam logic [TO_W-1:0] TO_LAST    = TO_W'(PKT_TIMEOUT - 1);

  logic [1:0]      state;
  logic [1:0]      grant_ch;
  logic            pkt_only;
  logic [6:0]      burst_cnt;
  logic [TO_W-1:0] to_cnt;
  logic            cap_dirty;
  logic            tout;
  logic            cmd_req, rsp_req, cap_req;
  logic            gnt_valid;
  logic [1:0]      gnt_ch;
  logic            in_xfer, active;
  logic            sel_cmd, sel_rsp, sel_cap;
  logic            cap_wr, rsp_wr;

  assign cmd_req = FIFO2_data_available & cmd_ready & ~cmd_valid;
  assign rsp_req = rsp_valid & FIFO5_ready_to_accept_data;
  // A pending timeout PKTEND competes as the capture channel.
  assign cap_req = (cap_valid & FIFO4_ready_to_accept_data) | tout;

  rr_arbiter3 u_arb (
    .FIFO_clk  (FIFO_clk),
    .reset     (reset),
    .req       ({cap_req, rsp_req, cmd_req}),
    .take      (state == ST_IDLE),
    .gnt_valid (gnt_valid),
    .gnt_ch    (gnt_ch)
  );

  assign in_xfer = (state == ST_XFER);
  assign active  = (state != ST_IDLE);
  assign sel_cmd = (grant_ch == CH_CMD);
  assign sel_rsp = (grant_ch == CH_RSP);
  assign sel_cap = (grant_ch == CH_CAP);

  assign FIFO_DATAIN_OE  = active & sel_cmd;
  assign FIFO_DATAOUT_OE = active & ~sel_cmd;
  assign FIFO_RD         = in_xfer & sel_cmd & cmd_req;
  assign cap_ready       = in_xfer & sel_cap & FIFO4_ready_to_accept_data;
  assign rsp_ready       = in_xfer & sel_rsp & FIFO5_ready_to_accept_data;
  assign cap_wr          = cap_valid & cap_ready;
  assign rsp_wr          = rsp_valid & rsp_ready;
  assign FIFO_WR         = cap_wr | rsp_wr;
  assign FIFO_PKTEND     = (state == ST_PKTEND);
  assign FIFO_DATAOUT    = sel_rsp ? rsp_data : cap_data;

  always_ff @(posedge FIFO_clk or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      grant_ch     <= CH_CMD;
      FIFO_FIFOADR <= FX2_ADR_EP2;
      pkt_only     <= 1'b0;
      burst_cnt    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (gnt_valid) begin
            grant_ch     <= gnt_ch;
            FIFO_FIFOADR <= ch_to_adr(gnt_ch);
            pkt_only     <= (gnt_ch == CH_CAP) & tout;
            burst_cnt    <= '0;
            state        <= ST_SETTLE;
          end
        end
        ST_SETTLE: state <= pkt_only ? ST_PKTEND : ST_XFER;
        ST_XFER: begin
          if (sel_cmd) begin
            state <= ST_IDLE;
          end else if (sel_rsp) begin
            if (rsp_wr && rsp_last) state <= ST_PKTEND;
          end else begin
            if (cap_wr) burst_cnt <= burst_cnt + 7'd1;
            if ((cap_wr && burst_cnt == BURST_LAST) || !cap_valid ||
                !FIFO4_ready_to_accept_data)
              state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Capture packet timeout: idle cycles counted only once EP6 holds data.
  always_ff @(posedge FIFO_clk or posedge reset) begin
    if (reset) begin
      to_cnt    <= '0;
      cap_dirty <= 1'b0;
      tout      <= 1'b0;
    end else if (cap_wr) begin
      to_cnt    <= '0;
      cap_dirty <= 1'b1;
      tout      <= 1'b0;
    end else if (FIFO_PKTEND && pkt_only) begin
      to_cnt    <= '0;
      cap_dirty <= 1'b0;
      tout      <= 1'b0;
    end else if (cap_dirty && !tout) begin
      if (to_cnt == TO_LAST) tout <= 1'b1;
      to_cnt <= to_cnt + TO_W'(1);
    end
  end

  always_ff @(posedge FIFO_clk or posedge reset) begin
    if (reset) begin
      cmd_valid <= 1'b0;
      cmd_data  <= 8'h00;
    end else if (FIFO_RD) begin
      cmd_valid <= 1'b1;
      cmd_data  <= FIFO_DATAIN;
    end else if (cmd_valid && cmd_ready) begin
      cmd_valid <= 1'b0;
    end
  end

endmodule
